// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush and load-use stall.
// Optional macro PIPE_STALL_CNT_EN adds a saturating 16-bit stall-cycle counter.
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ID_EX_MR,
    input  logic [4:0] ID_EX_DA,
    input  logic [4:0] IF_ID_AA,
    input  logic [4:0] IF_ID_BA,
    input  logic       Branch_Taken,
    input  logic       Mem_Req,
    input  logic       Mem_Ready,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       ID_EX_Write,
    output logic       EX_MEM_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       M_Stall,
    output logic       Mem_Timeout,
    output logic [1:0] Ctrl_State
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0] Stall_Cnt
`endif
);

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STALL_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_RSVD     = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_freeze;
    logic                w_branch;
    logic                w_load_use;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt_nxt;
    logic                r_timeout;

    // Hazard events are masked during reset so outputs show idle RUN behaviour.
    assign w_freeze   = rst_n & Mem_Req & ~Mem_Ready;
    assign w_branch   = rst_n & Branch_Taken;
    assign w_load_use = rst_n & ID_EX_MR & (ID_EX_DA != 5'd0) &
                        ((ID_EX_DA == IF_ID_AA) | (ID_EX_DA == IF_ID_BA));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority: freeze > taken branch > post-redirect squash > load-use.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        M_Stall      = 1'b0;
        w_next_state = ST_RUN;
        if (w_freeze) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            w_next_state = ST_MEM_WAIT;
        end else if (w_branch) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            w_next_state = ST_FLUSH;
        end else if (r_state == ST_FLUSH) begin
            // Squash the fetch issued while the PC was being redirected.
            IF_ID_Flush  = 1'b1;
            w_next_state = ST_RUN;
        end else if (w_load_use) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
            M_Stall      = 1'b1;
            w_next_state = ST_RUN;
        end
    end

    // Wait counter clears on entry to MEM_WAIT and saturates while waiting.
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (r_state != ST_MEM_WAIT) begin
            if (w_next_state == ST_MEM_WAIT) begin
                w_wait_cnt_nxt = '0;
            end
        end else if (r_wait_cnt != WAIT_MAX) begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= r_timeout | (w_wait_cnt_nxt == WAIT_MAX);
        end
    end

    assign Mem_Timeout = r_timeout;
    assign Ctrl_State  = r_state;

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall_cnt;

    // Counts cycles in which the PC is held, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!PC_Write && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign Stall_Cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ID_EX_MR;
    logic [4:0] ID_EX_DA;
    logic [4:0] IF_ID_AA;
    logic [4:0] IF_ID_BA;
    logic       Branch_Taken;
    logic       Mem_Req;
    logic       Mem_Ready;
    logic       PC_Write;
    logic       IF_ID_Write;
    logic       ID_EX_Write;
    logic       EX_MEM_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       M_Stall;
    logic       Mem_Timeout;
    logic [1:0] Ctrl_State;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0] Stall_Cnt;
`endif

    logic [6:0] outs;
    int n_tests = 0;
    int n_fail  = 0;

    // {PC, IF_ID, ID_EX, EX_MEM writes, IF_ID flush, ID_EX flush, M_Stall}
    localparam logic [6:0] O_IDLE   = 7'b1111000;
    localparam logic [6:0] O_FREEZE = 7'b0000000;
    localparam logic [6:0] O_BRANCH = 7'b1111110;
    localparam logic [6:0] O_SQUASH = 7'b1111100;
    localparam logic [6:0] O_LDUSE  = 7'b0011011;

    assign outs = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                   IF_ID_Flush, ID_EX_Flush, M_Stall};

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ID_EX_MR     (ID_EX_MR),
        .ID_EX_DA     (ID_EX_DA),
        .IF_ID_AA     (IF_ID_AA),
        .IF_ID_BA     (IF_ID_BA),
        .Branch_Taken (Branch_Taken),
        .Mem_Req      (Mem_Req),
        .Mem_Ready    (Mem_Ready),
        .PC_Write     (PC_Write),
        .IF_ID_Write  (IF_ID_Write),
        .ID_EX_Write  (ID_EX_Write),
        .EX_MEM_Write (EX_MEM_Write),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .M_Stall      (M_Stall),
        .Mem_Timeout  (Mem_Timeout),
        .Ctrl_State   (Ctrl_State)
`ifdef PIPE_STALL_CNT_EN
        ,
        .Stall_Cnt    (Stall_Cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge; outputs settle 1 unit later.
    task automatic drive(input logic mr, input logic [4:0] da, input logic [4:0] aa,
                         input logic [4:0] ba, input logic bt, input logic req,
                         input logic rdy);
        @(negedge clk);
        ID_EX_MR = mr; ID_EX_DA = da; IF_ID_AA = aa; IF_ID_BA = ba;
        Branch_Taken = bt; Mem_Req = req; Mem_Ready = rdy;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Events present while in reset must not show through.
        rst_n = 1'b0;
        ID_EX_MR = 1'b1; ID_EX_DA = 5'd5; IF_ID_AA = 5'd5; IF_ID_BA = 5'd0;
        Branch_Taken = 1'b1; Mem_Req = 1'b1; Mem_Ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, O_IDLE); end
        n_tests++; if (Ctrl_State !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", Ctrl_State); end
        n_tests++; if (Mem_Timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", Mem_Timeout); end
        idle();
        rst_n = 1'b1;
        idle();
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL run_idle: got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (outs !== O_LDUSE) begin n_fail++; $display("FAIL lduse_a: got %b want %b", outs, O_LDUSE); end
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        n_tests++; if (outs !== O_LDUSE) begin n_fail++; $display("FAIL lduse_b: got %b want %b", outs, O_LDUSE); end
        n_tests++; if (Ctrl_State !== 2'b00) begin n_fail++; $display("FAIL lduse_state: got %b want 00", Ctrl_State); end
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL lduse_r0: got %b want %b", outs, O_IDLE); end
        drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL lduse_nomr: got %b want %b", outs, O_IDLE); end
        drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0);
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL lduse_nomatch: got %b want %b", outs, O_IDLE); end
        idle();
    endtask

    task automatic test_branch();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (outs !== O_BRANCH) begin n_fail++; $display("FAIL br_c0: got %b want %b", outs, O_BRANCH); end
        n_tests++; if (Ctrl_State !== 2'b00) begin n_fail++; $display("FAIL br_c0_state: got %b want 00", Ctrl_State); end
        idle();
        n_tests++; if (outs !== O_SQUASH) begin n_fail++; $display("FAIL br_c1: got %b want %b", outs, O_SQUASH); end
        n_tests++; if (Ctrl_State !== 2'b10) begin n_fail++; $display("FAIL br_c1_state: got %b want 10", Ctrl_State); end
        idle();
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL br_c2: got %b want %b", outs, O_IDLE); end
        n_tests++; if (Ctrl_State !== 2'b00) begin n_fail++; $display("FAIL br_c2_state: got %b want 00", Ctrl_State); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (outs !== O_BRANCH) begin n_fail++; $display("FAIL b2b_rebranch: got %b want %b", outs, O_BRANCH); end
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (outs !== O_SQUASH) begin n_fail++; $display("FAIL b2b_squash_over_lduse: got %b want %b", outs, O_SQUASH); end
        n_tests++; if (Ctrl_State !== 2'b10) begin n_fail++; $display("FAIL b2b_state: got %b want 10", Ctrl_State); end
        idle();
        n_tests++; if (Ctrl_State !== 2'b00) begin n_fail++; $display("FAIL b2b_end_state: got %b want 00", Ctrl_State); end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            n_tests++; if (outs !== O_FREEZE) begin n_fail++; $display("FAIL mw_freeze%0d: got %b want %b", i, outs, O_FREEZE); end
            n_tests++; if (Ctrl_State !== ((i == 0) ? 2'b00 : 2'b01)) begin n_fail++; $display("FAIL mw_state%0d: got %b want %b", i, Ctrl_State, (i == 0) ? 2'b00 : 2'b01); end
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL mw_ready: got %b want %b", outs, O_IDLE); end
        n_tests++; if (Ctrl_State !== 2'b01) begin n_fail++; $display("FAIL mw_ready_state: got %b want 01", Ctrl_State); end
        idle();
        n_tests++; if (Ctrl_State !== 2'b00) begin n_fail++; $display("FAIL mw_exit_state: got %b want 00", Ctrl_State); end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
        n_tests++; if (outs !== O_FREEZE) begin n_fail++; $display("FAIL sim_c0: got %b want %b", outs, O_FREEZE); end
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
        n_tests++; if (outs !== O_FREEZE) begin n_fail++; $display("FAIL sim_c1: got %b want %b", outs, O_FREEZE); end
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1);
        n_tests++; if (outs !== O_BRANCH) begin n_fail++; $display("FAIL sim_ready_branch: got %b want %b", outs, O_BRANCH); end
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (outs !== O_SQUASH) begin n_fail++; $display("FAIL sim_squash: got %b want %b", outs, O_SQUASH); end
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (outs !== O_LDUSE) begin n_fail++; $display("FAIL sim_lduse: got %b want %b", outs, O_LDUSE); end
        idle();
    endtask

    task automatic test_reset_mid_flush();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        n_tests++; if (Ctrl_State !== 2'b00) begin n_fail++; $display("FAIL rstflush_state: got %b want 00", Ctrl_State); end
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL rstflush_outs: got %b want %b", outs, O_IDLE); end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            if (i == 1) begin
                n_tests++; if (Ctrl_State !== 2'b01) begin n_fail++; $display("FAIL to_state: got %b want 01", Ctrl_State); end
            end
            if (i == 255) begin
                n_tests++; if (Mem_Timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0 at cycle %0d", Mem_Timeout, i); end
            end
            if (i == 256) begin
                n_tests++; if (Mem_Timeout !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b want 1 at cycle %0d", Mem_Timeout, i); end
            end
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL to_ready: got %b want %b", outs, O_IDLE); end
        idle();
        n_tests++; if (Mem_Timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", Mem_Timeout); end
        n_tests++; if (Ctrl_State !== 2'b00) begin n_fail++; $display("FAIL to_exit_state: got %b want 00", Ctrl_State); end
        repeat (2) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        n_tests++; if (Ctrl_State !== 2'b00) begin n_fail++; $display("FAIL rstwait_state: got %b want 00", Ctrl_State); end
        n_tests++; if (Mem_Timeout !== 1'b0) begin n_fail++; $display("FAIL rstwait_timeout: got %b want 0", Mem_Timeout); end
        n_tests++; if (outs !== O_IDLE) begin n_fail++; $display("FAIL rstwait_outs: got %b want %b", outs, O_IDLE); end
        idle();
        rst_n = 1'b1;
        idle();
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        pulse_reset();
        idle();
        n_tests++; if (Stall_Cnt !== 16'd0) begin n_fail++; $display("FAIL sc_zero: got %0d want 0", Stall_Cnt); end
        repeat (10) drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        n_tests++; if (Stall_Cnt !== 16'd14) begin n_fail++; $display("FAIL sc_count: got %0d want 14", Stall_Cnt); end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_mem_wait();
        test_simultaneous();
        test_reset_mid_flush();
        test_timeout();
`ifdef PIPE_STALL_CNT_EN
        test_stall_cnt();
`else
        pulse_reset();
        idle();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
